// File: rtl/dpram_pkg.sv
// dpram_pkg: shared defaults and types for the dual-port RAM slice.
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default word and address widths
//   depth_of()                      : number of words for a given address width
//   DEPTH_DEF                       : default depth (16)
//   data_t / addr_t                 : word and address types at default widths
package dpram_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  // Every address pattern maps to a real word, so depth is a full power of two.
  function automatic int depth_of(input int addr_width);
    return 32'sd1 << addr_width;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_WIDTH_DEF);

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

endpackage

// File: rtl/dpram_design_if.sv
// dpram_design_if: write/read port bundle of the dual-port RAM.
//   wr_en, wr_addr, data_in : write port (driven by master)
//   rd_en, rd_addr          : read request (driven by master)
//   data_out                : registered read data (driven by slave)
// Modports: master (requester side), slave (RAM side).
interface dpram_design_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output wr_en, wr_addr, data_in, rd_en, rd_addr,
    input  data_out
  );

  modport slave (
    input  wr_en, wr_addr, data_in, rd_en, rd_addr,
    output data_out
  );

endinterface

// File: rtl/dpram_mem_array.sv
// dpram_mem_array: storage array of the dual-port RAM.
//   clk, rst          : clock, asynchronous active-low clear of every word
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_addr/rd_data   : combinational (unregistered) read port
module dpram_mem_array
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Write port; reset clears every word, which also drops a write set up when reset hits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en == 1'b1) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  // Unregistered read: shows contents before this edge's write (read-first base).
  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/dpram_design.sv
// dpram_design: single-clock dual-port RAM with registered read data.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset (clears data_out and memory)
//   bus      : dpram_design_if.slave (write port, read request, data_out)
// Build option: DPRAM_BYPASS_EN -- when defined, a same-address read and write
// in one cycle returns the new write data (write-first); otherwise the old
// contents are returned (read-first).
module dpram_design
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  dpram_design_if.slave  bus
);

  logic [DATA_WIDTH-1:0] mem_rd_s;
  logic [DATA_WIDTH-1:0] rd_sel_s;
  logic [DATA_WIDTH-1:0] data_out_r;

  dpram_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.data_in),
    .rd_addr (bus.rd_addr),
    .rd_data (mem_rd_s)
  );

`ifdef DPRAM_BYPASS_EN
  logic collide_s;

  // Same-address collision forwards the incoming write word.
  always_comb begin
    collide_s = 1'b0;
    rd_sel_s  = mem_rd_s;
    if ((bus.wr_en == 1'b1) && (bus.rd_en == 1'b1) && (bus.wr_addr == bus.rd_addr)) begin
      collide_s = 1'b1;
    end else begin
      collide_s = 1'b0;
    end
    if (collide_s) begin
      rd_sel_s = bus.data_in;
    end else begin
      rd_sel_s = mem_rd_s;
    end
  end
`else
  // Read-first: the array output already holds pre-write contents.
  always_comb begin
    rd_sel_s = mem_rd_s;
  end
`endif

  // Read data register; holds its value when no read is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_r <= '0;
    end else if (bus.rd_en == 1'b1) begin
      data_out_r <= rd_sel_s;
    end else begin
      data_out_r <= data_out_r;
    end
  end

  assign bus.data_out = data_out_r;

endmodule

// File: tb/tb_dpram_design.sv
module tb_dpram_design;
  import dpram_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dpram_design_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  dpram_design #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_addr = 4'd0;
    bus.rd_addr = 4'd0;
    bus.data_in = 8'd0;
  endtask

  // One cycle: inputs applied at negedge, effect visible at the following negedge.
  task automatic do_cycle(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                          input logic re, input logic [3:0] ra);
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.data_in = wd;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_init: data_out=%h expected=%h", bus.data_out, 8'h00);
    end
    #20;
    @(negedge clk);
    rst = 1'b1;
    // Make data_out nonzero, then reset between clock edges.
    do_cycle(1'b1, 4'd0, 8'h5C, 1'b0, 4'd0);
    do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd0);
    checks++;
    if (bus.data_out !== 8'h5C) begin
      errors++;
      $display("FAIL reset_pre: data_out=%h expected=%h", bus.data_out, 8'h5C);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: data_out=%h expected=%h", bus.data_out, 8'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 16; a++) begin
      do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
      checks++;
      if (bus.data_out !== 8'h00) begin
        errors++;
        $display("FAIL reset_clear: addr=%0d data_out=%h expected=%h", a, bus.data_out, 8'h00);
      end
    end
  endtask

  task automatic test_basic();
    do_cycle(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
    do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    checks++;
    if (bus.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL basic_read: data_out=%h expected=%h", bus.data_out, 8'hA5);
    end
    // rd_en low with a different address: output must hold.
    do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd7);
    checks++;
    if (bus.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL basic_hold: data_out=%h expected=%h", bus.data_out, 8'hA5);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    for (int a = 0; a < 16; a++) begin
      do_cycle(1'b1, 4'(a), 8'(a) ^ 8'h5A, 1'b0, 4'd0);
    end
    for (int a = 0; a < 16; a++) begin
      exp = 8'(a) ^ 8'h5A;
      do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
      checks++;
      if (bus.data_out !== exp) begin
        errors++;
        $display("FAIL sweep: addr=%0d data_out=%h expected=%h", a, bus.data_out, exp);
      end
    end
  endtask

  task automatic test_concurrent();
    do_cycle(1'b1, 4'd7, 8'h77, 1'b0, 4'd0);
    do_cycle(1'b1, 4'd2, 8'h11, 1'b1, 4'd7);
    checks++;
    if (bus.data_out !== 8'h77) begin
      errors++;
      $display("FAIL concurrent_read: data_out=%h expected=%h", bus.data_out, 8'h77);
    end
    do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
    checks++;
    if (bus.data_out !== 8'h11) begin
      errors++;
      $display("FAIL concurrent_write: data_out=%h expected=%h", bus.data_out, 8'h11);
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp;
`ifdef DPRAM_BYPASS_EN
    exp = 8'hCC;
`else
    exp = 8'h33;
`endif
    do_cycle(1'b1, 4'd5, 8'h33, 1'b0, 4'd0);
    do_cycle(1'b1, 4'd5, 8'hCC, 1'b1, 4'd5);
    checks++;
    if (bus.data_out !== exp) begin
      errors++;
      $display("FAIL collision: data_out=%h expected=%h", bus.data_out, exp);
    end
    do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    checks++;
    if (bus.data_out !== 8'hCC) begin
      errors++;
      $display("FAIL collision_after: data_out=%h expected=%h", bus.data_out, 8'hCC);
    end
  endtask

  task automatic test_reset_mid_write();
    do_cycle(1'b1, 4'd9, 8'h42, 1'b0, 4'd0);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd9;
    bus.data_in = 8'hFF;
    #2;
    rst = 1'b0;
    @(negedge clk);
    // First edge after release is a normal read of addr 9.
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'd9;
    @(negedge clk);
    bus.rd_en = 1'b0;
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_write: data_out=%h expected=%h", bus.data_out, 8'h00);
    end
    // Port works normally afterwards.
    do_cycle(1'b1, 4'd9, 8'h3C, 1'b0, 4'd0);
    do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd9);
    checks++;
    if (bus.data_out !== 8'h3C) begin
      errors++;
      $display("FAIL post_reset_write: data_out=%h expected=%h", bus.data_out, 8'h3C);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_sweep();
    test_concurrent();
    test_collision();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_design.md
DPRAM_DESIGN -- requirements
Module: dpram_design

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the width of the data word.
REQ-003 Parameter ADDR_WIDTH, default 4, SHALL set the address width; DEPTH SHALL equal 2**ADDR_WIDTH (default 16).
REQ-004 clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 wr_en  input  1  SHALL be the write strobe, sampled on the rising clk edge.
REQ-007 wr_addr  input  ADDR_WIDTH  SHALL be the write address.
REQ-008 data_in  input  DATA_WIDTH  SHALL be the write data.
REQ-009 rd_en  input  1  SHALL be the read strobe, sampled on the rising clk edge.
REQ-010 rd_addr  input  ADDR_WIDTH  SHALL be the read address.
REQ-011 data_out  output  DATA_WIDTH  SHALL carry the registered read data.

Function
REQ-012 When wr_en=1 at a rising clk edge, mem[wr_addr] SHALL take data_in.
REQ-013 When rd_en=1 at a rising clk edge, data_out SHALL take mem[rd_addr]; read latency is one cycle.
REQ-014 When rd_en=0, data_out SHALL hold its previous value.
REQ-015 Write and read ports SHALL be independent; both may be active in the same cycle at any address pair.
REQ-016 Different-address simultaneous read and write: the read SHALL return the stored old contents and the write SHALL complete normally.
REQ-017 Same-address simultaneous read and write: the returned value SHALL be as defined in REQ-022/REQ-023; the write SHALL always complete.
REQ-018 Addresses SHALL cover 0..DEPTH-1 fully with no wrap logic; there is no out-of-range case.
REQ-019 X or Z values on wr_en or rd_en SHALL be treated as 0 (no write, no read).

Reset
REQ-020 While rst=0, data_out SHALL be 0 immediately, without waiting for a clock edge, and every memory location SHALL be 0.
REQ-021 Reset asserted mid-operation SHALL abort any pending write; after rst rises, the first rising edge SHALL behave as a normal cycle.

Configuration
REQ-022 With DPRAM_BYPASS_EN defined, a same-address read/write in one cycle SHALL return data_in on data_out (write-first).
REQ-023 Without DPRAM_BYPASS_EN, a same-address read/write SHALL return the pre-write contents (read-first); all other behaviour SHALL be identical in both builds.

Structure
REQ-024 Package dpram_pkg SHALL hold DATA_WIDTH_DEF, ADDR_WIDTH_DEF, the DEPTH derivation, and typedefs data_t and addr_t.
REQ-025 Storage SHALL live in one sub-module, dpram_mem_array, containing the array, the write port, async clear and an unregistered read port.
REQ-026 The top level SHALL hold the data_out register and the collision/bypass compare logic.

Verification
REQ-027 Reset: drive rst=0 with data_out previously nonzero -> data_out=0 without a clock edge; after release, reading addresses 0..15 returns 0.
REQ-028 Basic write/read: write 8'hA5 to addr 3, then rd_en=1 with rd_addr=3 -> data_out=8'hA5 one cycle later; with rd_en=0 afterwards, data_out stays 8'hA5.
REQ-029 Full sweep: write data=addr^8'h5A to all 16 addresses, then read all 16 -> each data_out matches its written value.
REQ-030 Concurrent ports: write 8'h11 to addr 2 while reading addr 7 (holding 8'h77) -> data_out=8'h77 and mem[2]=8'h11.
REQ-031 Collision at addr 5 (old 8'h33, new 8'hCC) -> data_out=8'hCC with DPRAM_BYPASS_EN, 8'h33 without; a subsequent read returns 8'hCC in both builds.
REQ-032 Reset mid-write: assert rst between the setup and edge of a write of 8'hFF to addr 9 -> mem[9] reads 0 after release.
